// File: rtl/instr_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
// Default word layout is {opcode[7:4], operand[3:0]}.
package instr_pkg;

  localparam int INST_W_DEF = 8;
  localparam int OPC_W_DEF  = 4;
  localparam int OPD_W_DEF  = INST_W_DEF - OPC_W_DEF;

  localparam logic [OPC_W_DEF-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W_DEF-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W_DEF-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W_DEF-1:0] OP_AND = 4'h3;
  localparam logic [OPC_W_DEF-1:0] OP_OR  = 4'h4;
  localparam logic [OPC_W_DEF-1:0] OP_LDA = 4'h5;
  localparam logic [OPC_W_DEF-1:0] OP_STA = 4'h6;
  localparam logic [OPC_W_DEF-1:0] OP_JMP = 4'h7;

  typedef struct packed {
    logic [OPC_W_DEF-1:0] opc;
    logic [OPD_W_DEF-1:0] opd;
  } inst_t;

  function automatic inst_t split_inst(
    input logic [INST_W_DEF-1:0] w
  );
    inst_t r;
    r.opc = w[INST_W_DEF-1 -: OPC_W_DEF];
    r.opd = w[OPD_W_DEF-1:0];
    return r;
  endfunction

endpackage

// File: rtl/instr_queue_reg_iq_storage.sv
// Queue storage: DEPTH x INST_W registers, one write port,
// one asynchronous read port. Contents are intentionally not reset.
module iq_storage #(
  parameter int INST_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue_reg.sv
// Instruction register with in-order prefetch queue (fetch -> decode).
// Optional IQ_BYPASS_EN: empty-queue words reach OpCode/Operand same cycle.
module instr_queue_reg
  import instr_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Flush,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [INST_W-1:0]          Inst,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [OPC_W-1:0]           OpCode,
  output logic [INST_W-OPC_W-1:0]    Operand,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [INST_W-1:0] rd_data;
  logic [INST_W-1:0] head;
  logic              empty;
  logic              full;
  logic              byp;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              rd_adv;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign Count = cnt;

  always_comb begin
    In_Ready = !Rst && !full;
    byp      = 1'b0;
`ifdef IQ_BYPASS_EN
    byp      = empty && In_Valid && !Rst && !Flush;
`endif
    Out_Valid = !empty || byp;
    head      = byp ? Inst : rd_data;
    push      = In_Valid && In_Ready;
    pop       = Out_Valid && Out_Ready;
    // a bypassed word that is consumed at once never occupies a slot
    wr_en     = push && !(byp && Out_Ready);
    rd_adv    = pop && !byp;
    cnt_nxt   = cnt + CW'(wr_en) - CW'(rd_adv);
    OpCode    = Out_Valid ? head[INST_W-1 -: OPC_W] : '0;
    Operand   = Out_Valid ? head[INST_W-OPC_W-1:0] : '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst || Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt_nxt;
    end
  end

  iq_storage #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_storage (
    .Clk   (Clk),
    .we    (wr_en && !Flush),
    .waddr (wr_ptr),
    .wdata (Inst),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_instr_queue_reg.sv
// Bench for instr_queue_reg: vector table, wrap sequence, random run.
// Reference is a plain word queue; IQ_BYPASS_EN selects bypass expectations.
module tb_instr_queue_reg;

`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Flush;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] Inst;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [3:0] OpCode;
  logic [3:0] Operand;
  logic [2:0] Count;

  int total = 0;
  int passed = 0;

  logic [7:0] q [$];

  always #5 Clk = ~Clk;

  instr_queue_reg dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Inst      (Inst),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .OpCode    (OpCode),
    .Operand   (Operand),
    .Count     (Count)
  );

  typedef struct {
    bit       rst;
    bit       flush;
    bit       iv;
    bit [7:0] inst;
    bit       ordy;
    bit       ov;
    bit [7:0] head;
    int       cnt;
    bit       ir;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit r, input bit f, input bit iv,
                       input bit [7:0] w, input bit ordy);
    bit       e_ov;
    bit [7:0] e_head;
    Rst = r; Flush = f; In_Valid = iv; Inst = w; Out_Ready = ordy;
    @(negedge Clk);
    e_ov   = (q.size() != 0) || (BYP && iv && !r && !f);
    e_head = (q.size() != 0) ? q[0] : (e_ov ? w : 8'h00);
    chk("m_ov", Out_Valid, e_ov);
    chk("m_opc", OpCode, e_ov ? e_head[7:4] : 0);
    chk("m_opd", Operand, e_ov ? e_head[3:0] : 0);
    chk("m_cnt", Count, q.size());
    chk("m_ir", In_Ready, !r && q.size() != 4);
  endtask

  task automatic tick();
    int  n;
    bit  iv, ordy;
    n = q.size();
    iv = In_Valid; ordy = Out_Ready;
    @(posedge Clk);
    if (Rst || Flush) q.delete();
    else if (BYP && n == 0 && iv && ordy) begin
    end else begin
      if (ordy && n > 0) void'(q.pop_front());
      if (iv && n < 4) q.push_back(Inst);
    end
    #1;
  endtask

  vec_t tv [$];

  function automatic vec_t v(bit r, bit f, bit iv, bit [7:0] w, bit ordy,
                             bit ov, bit [7:0] h, int c, bit ir);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.inst = w; t.ordy = ordy;
    t.ov = ov; t.head = h; t.cnt = c; t.ir = ir;
    return t;
  endfunction

  initial begin
    bit [7:0] exp_pop;
    bit [7:0] bh;
    Rst = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Inst = '0; Out_Ready = 1'b0;
    @(posedge Clk); #1;
    q.delete();

    // T1 reset, T2 fill/drain, T4 full+pop, T5 flush, T6 empty push
    tv.push_back(v(1,0,1,8'hA5,0, 0,8'h00,0,0));
    tv.push_back(v(1,0,1,8'hA5,0, 0,8'h00,0,0));
    tv.push_back(v(0,0,1,8'h12,0, BYP,BYP?8'h12:8'h00,0,1));
    tv.push_back(v(0,0,1,8'h34,0, 1,8'h12,1,1));
    tv.push_back(v(0,0,1,8'h56,0, 1,8'h12,2,1));
    tv.push_back(v(0,0,1,8'h78,0, 1,8'h12,3,1));
    tv.push_back(v(0,0,0,8'h00,0, 1,8'h12,4,0));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h12,4,0));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h34,3,1));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h56,2,1));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h78,1,1));
    tv.push_back(v(0,0,0,8'h00,0, 0,8'h00,0,1));
    tv.push_back(v(0,0,1,8'h11,0, BYP,BYP?8'h11:8'h00,0,1));
    tv.push_back(v(0,0,1,8'h22,0, 1,8'h11,1,1));
    tv.push_back(v(0,0,1,8'h33,0, 1,8'h11,2,1));
    tv.push_back(v(0,0,1,8'h44,0, 1,8'h11,3,1));
    tv.push_back(v(0,0,1,8'h9C,1, 1,8'h11,4,0));
    tv.push_back(v(0,0,1,8'h9C,0, 1,8'h22,3,1));
    tv.push_back(v(0,0,0,8'h00,0, 1,8'h22,4,0));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h22,4,0));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h33,3,1));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h44,2,1));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'h9C,1,1));
    tv.push_back(v(0,0,1,8'h5A,0, BYP,BYP?8'h5A:8'h00,0,1));
    tv.push_back(v(0,0,1,8'h6B,0, 1,8'h5A,1,1));
    tv.push_back(v(0,0,1,8'h7C,0, 1,8'h5A,2,1));
    tv.push_back(v(0,1,1,8'hEE,1, 1,8'h5A,3,1));
    tv.push_back(v(0,0,0,8'h00,0, 0,8'h00,0,1));
    tv.push_back(v(0,0,1,8'hC3,0, BYP,BYP?8'hC3:8'h00,0,1));
    tv.push_back(v(0,0,0,8'h00,0, 1,8'hC3,1,1));
    tv.push_back(v(0,0,0,8'h00,1, 1,8'hC3,1,1));
    tv.push_back(v(0,0,1,8'hC3,1, BYP,BYP?8'hC3:8'h00,0,1));
    tv.push_back(v(0,0,0,8'h00,0, !BYP,BYP?8'h00:8'hC3,BYP?0:1,1));
    tv.push_back(v(0,0,0,8'h00,1, !BYP,BYP?8'h00:8'hC3,BYP?0:1,1));
    tv.push_back(v(0,0,0,8'h00,0, 0,8'h00,0,1));

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].flush, tv[i].iv, tv[i].inst, tv[i].ordy);
      bh = tv[i].head;
      chk($sformatf("v%0d_ov", i), Out_Valid, tv[i].ov);
      chk($sformatf("v%0d_opc", i), OpCode, bh[7:4]);
      chk($sformatf("v%0d_opd", i), Operand, bh[3:0]);
      chk($sformatf("v%0d_cnt", i), Count, tv[i].cnt);
      chk($sformatf("v%0d_ir", i), In_Ready, tv[i].ir);
      tick();
    end

    // T3 wrap: 01..06 through the queue, occupancy kept within 1..3
    exp_pop = 8'h01;
    drive(0,0,1,8'h01,0); tick();
    drive(0,0,1,8'h02,0); tick();
    for (int k = 3; k <= 8; k++) begin
      drive(0,0,k <= 6,8'(k),1);
      chk("wrap_pop", {OpCode, Operand}, exp_pop);
      chk("wrap_cnt_range", (Count >= 1 && Count <= 3), 1);
      exp_pop++;
      tick();
    end
    drive(0,0,0,8'h00,0);
    chk("wrap_empty", Out_Valid, 0);
    tick();

    // random run with occasional mid-operation reset and flush
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0,39) == 0, $urandom_range(0,24) == 0,
            $urandom_range(0,9) < 6, 8'($urandom), $urandom_range(0,1) == 1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
